// File: rtl/elevator_floor_tracker_if.sv
// elevator_floor_tracker_if
//   Groups the car-side signals of the floor tracker. The master modport is
//   the environment: tick generator, call buttons and safety inputs. The
//   slave modport is the tracker itself.
//   Signals:
//     move_clk              step stream from the tick generator
//     call[2:0]             floor-call pulses (bit0 = floor 1 .. bit2 = floor 3)
//     sos_mode              emergency: flush and block calls
//     weight_limit_exceeded overload: holds the door open
//     led1/led2/led3        car stopped exactly at floor 1/2/3
//     move_handler          1 = car in motion, the generator counts
//     door_open             door dwell active
//     dir_up                current or last travel direction
//     floor[1:0]            last floor reached, 0..2
//     pending[2:0]          latched outstanding calls
//     floor_seg[6:0]        seven-segment floor display (ELEVATOR_SEG_EN only)
`timescale 1ns/1ps
interface elevator_floor_tracker_if;
  logic       move_clk;
  logic [2:0] call;
  logic       sos_mode;
  logic       weight_limit_exceeded;
  logic       led1;
  logic       led2;
  logic       led3;
  logic       move_handler;
  logic       door_open;
  logic       dir_up;
  logic [1:0] floor;
  logic [2:0] pending;
`ifdef ELEVATOR_SEG_EN
  logic [6:0] floor_seg;
`endif

  modport master (
    output move_clk, call, sos_mode, weight_limit_exceeded,
    input  led1, led2, led3, move_handler, door_open, dir_up, floor, pending
`ifdef ELEVATOR_SEG_EN
    , input floor_seg
`endif
  );

  modport slave (
    input  move_clk, call, sos_mode, weight_limit_exceeded,
    output led1, led2, led3, move_handler, door_open, dir_up, floor, pending
`ifdef ELEVATOR_SEG_EN
    , output floor_seg
`endif
  );
endinterface

// File: rtl/elevator_floor_tracker.sv
// elevator_floor_tracker
//   Tracks a 3-floor car from the move-tick stream, serves latched floor
//   calls, runs the door dwell and tells the tick generator whether to count.
//   Ports:
//     clk             system clock
//     button_reset_n  asynchronous active-low reset
//     bus             elevator_floor_tracker_if.slave (see the interface file)
//   Parameters:
//     TICKS_PER_FLOOR move_clk rising edges per inter-floor segment (2..255)
//     DOOR_TIME       door dwell length in clk cycles (1..65535)
//   Optional feature:
//     ELEVATOR_SEG_EN adds the registered active-low seven-segment output
//                     floor_seg (g..a) showing floor+1, or "-" between floors.
`timescale 1ns/1ps
module elevator_floor_tracker #(
  parameter int unsigned TICKS_PER_FLOOR = 4,
  parameter int unsigned DOOR_TIME       = 20
) (
  input  logic                     clk,
  input  logic                     button_reset_n,
  elevator_floor_tracker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  localparam logic [7:0]  TPF = 8'(TICKS_PER_FLOOR);
  localparam logic [15:0] DT  = 16'(DOOR_TIME);

  // Calls strictly above / below a floor, and the floor's own bit.
  function automatic logic [2:0] above_mask(input logic [1:0] f);
    case (f)
      2'd0:    above_mask = 3'b110;
      2'd1:    above_mask = 3'b100;
      default: above_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below_mask(input logic [1:0] f);
    case (f)
      2'd1:    below_mask = 3'b001;
      2'd2:    below_mask = 3'b011;
      default: below_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] floor_bit(input logic [1:0] f);
    floor_bit = 3'(3'b001 << f);
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  floor_q, floor_d;
  logic [7:0]  pos_q, pos_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  led_q, led_d;
  logic        dir_q, dir_d;
  logic        mh_q, door_q;
  logic        prev_q;

  logic        step;
  logic [2:0]  call_eff;
  logic [2:0]  pend_live;
  logic [2:0]  pend_old;
  logic [2:0]  clr;
  logic [2:0]  ahead;

  // move_clk is already synchronous to clk, so a single delay register is
  // enough for edge detection.
  assign step = bus.move_clk & ~prev_q;

  // NOTE: every signal assigned here gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    pos_d   = pos_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    clr     = 3'b000;
    ahead   = 3'b000;

    // Emergency mode blocks new calls and hides latched ones from every
    // decision; the latched set itself is flushed below.
    call_eff  = bus.sos_mode ? 3'b000 : bus.call;
    pend_old  = bus.sos_mode ? 3'b000 : pend_q;
    pend_live = pend_old | call_eff;

    unique case (state_q)
      IDLE: begin
        if ((pend_live & floor_bit(floor_q)) != 3'b000) begin
          // A call for the floor the car is parked at just opens the door.
          state_d = DOOR;
          timer_d = DT;
          clr     = floor_bit(floor_q);
        end else if ((pend_old & above_mask(floor_q)) != 3'b000 &&
                     (dir_q || (pend_old & below_mask(floor_q)) == 3'b000)) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end else if ((pend_old & below_mask(floor_q)) != 3'b000) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end

      DOOR: begin
        if (call_eff[floor_q]) begin
          timer_d = DT;
          clr     = floor_bit(floor_q);
        end else if (bus.weight_limit_exceeded) begin
          timer_d = timer_q;
        end else if (timer_q <= 16'd1) begin
          state_d = IDLE;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (step) begin
          if (pos_q + 8'd1 == TPF) begin
            pos_d = 8'd0;
            if (state_q == MOVE_UP) begin
              floor_d = (floor_q == 2'd2) ? floor_q : floor_q + 2'd1;
              ahead   = above_mask(floor_d);
            end else begin
              floor_d = (floor_q == 2'd0) ? floor_q : floor_q - 2'd1;
              ahead   = below_mask(floor_d);
            end
            // A call for the arrival floor on this very edge is folded into
            // pend_live, so it causes the stop and is cleared with it.
            if ((pend_live & floor_bit(floor_d)) != 3'b000 ||
                (pend_live & ahead) == 3'b000) begin
              state_d = DOOR;
              timer_d = DT;
              clr     = floor_bit(floor_d);
            end
          end else begin
            pos_d = pos_q + 8'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    pend_d = bus.sos_mode ? 3'b000 : (pend_live & ~clr);
    led_d  = (pos_d == 8'd0) ? floor_bit(floor_d) : 3'b000;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge button_reset_n) begin
    if (!button_reset_n) begin
      state_q <= IDLE;
      floor_q <= 2'd0;
      pos_q   <= 8'd0;
      timer_q <= 16'd0;
      pend_q  <= 3'b000;
      led_q   <= 3'b001;
      dir_q   <= 1'b1;
      mh_q    <= 1'b0;
      door_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      pos_q   <= pos_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      mh_q    <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
      door_q  <= (state_d == DOOR);
      prev_q  <= bus.move_clk;
    end
  end

  assign bus.led1         = led_q[0];
  assign bus.led2         = led_q[1];
  assign bus.led3         = led_q[2];
  assign bus.move_handler = mh_q;
  assign bus.door_open    = door_q;
  assign bus.dir_up       = dir_q;
  assign bus.floor        = floor_q;
  assign bus.pending      = pend_q;

`ifdef ELEVATOR_SEG_EN
  // Active-low segments ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [6:0] seg_q, seg_d;

  always_comb begin
    seg_d = SEG_DASH;
    if (pos_d == 8'd0) begin
      case (floor_d)
        2'd0:    seg_d = SEG_1;
        2'd1:    seg_d = SEG_2;
        default: seg_d = SEG_3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge button_reset_n) begin
    if (!button_reset_n) seg_q <= SEG_1;
    else                 seg_q <= seg_d;
  end

  assign bus.floor_seg = seg_q;
`endif

endmodule

// File: tb/tb_elevator_floor_tracker.sv
// tb_elevator_floor_tracker
//   Directed scenarios for the floor tracker. Stimulus pushes hand-computed
//   expected output snapshots tagged with the cycle they apply to; a monitor
//   on the falling clock edge pops and compares them.
`timescale 1ns/1ps
module tb_elevator_floor_tracker;

  logic        clk = 1'b0;
  logic        button_reset_n;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  elevator_floor_tracker_if bus ();

  elevator_floor_tracker #(
    .TICKS_PER_FLOOR(4),
    .DOOR_TIME      (20)
  ) dut (
    .clk           (clk),
    .button_reset_n(button_reset_n),
    .bus           (bus)
  );

  // Snapshot layout: {led1,led2,led3, move_handler, door_open, dir_up, floor[1:0], pending[2:0]}
  typedef struct {
    int unsigned cyc;
    string       name;
    logic [10:0] exp;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One move_clk pulse; the step is taken on the first edge.
  task automatic step_hi();
    bus.move_clk = 1'b1;
    tick();
    bus.move_clk = 1'b0;
  endtask

  task automatic step();
    step_hi();
    tick();
  endtask

  // Expectation for the state following the most recent rising edge.
  task automatic expect_out(input string name, input logic [2:0] led123,
                            input logic mh, input logic door, input logic dir,
                            input logic [1:0] fl, input logic [2:0] pend);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.exp  = {led123, mh, door, dir, fl, pend};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [10:0] act;
    exp_t        e;
    act = {bus.led1, bus.led2, bus.led3, bus.move_handler, bus.door_open,
           bus.dir_up, bus.floor, bus.pending};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got led123/mh/door/dir/floor/pend=%b expected %b (cycle %0d, due %0d)",
                 e.name, act, e.exp, cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    button_reset_n            = 1'b0;
    bus.move_clk              = 1'b0;
    bus.call                  = 3'b000;
    bus.sos_mode              = 1'b0;
    bus.weight_limit_exceeded = 1'b0;

    // Reset and quiet idle.
    repeat (3) tick();
    check("reset_led1", 32'(bus.led1), 32'd1);
    check("reset_led23", 32'({bus.led2, bus.led3}), 32'd0);
    check("reset_move_handler", 32'(bus.move_handler), 32'd0);
    check("reset_floor", 32'(bus.floor), 32'd0);
    check("reset_pending", 32'(bus.pending), 32'd0);
    expect_out("reset", 3'b100, 0, 0, 1, 2'd0, 3'b000);
    button_reset_n = 1'b1;
    repeat (3) tick();
    expect_out("idle_after_reset", 3'b100, 0, 0, 1, 2'd0, 3'b000);

    // Call floor 3 from floor 1: passes floor 2, stops at floor 3.
    bus.call = 3'b100; tick(); bus.call = 3'b000;
    expect_out("call3_latched", 3'b100, 0, 0, 1, 2'd0, 3'b100);
    tick();
    expect_out("move_start", 3'b100, 1, 0, 1, 2'd0, 3'b100);
    step_hi();
    expect_out("led1_drop", 3'b000, 1, 0, 1, 2'd0, 3'b100);
    tick();
    step(); step();
    step_hi();
    expect_out("pass_f2", 3'b010, 1, 0, 1, 2'd1, 3'b100);
    tick();
    step(); step(); step();
    bus.call = 3'b100;   // call at the arrival floor on the arrival edge
    step_hi();
    bus.call = 3'b000;
    expect_out("arrive_f3", 3'b001, 0, 1, 1, 2'd2, 3'b000);
    repeat (19) tick();
    expect_out("door_f3_last", 3'b001, 0, 1, 1, 2'd2, 3'b000);
    tick();
    expect_out("door_f3_closed", 3'b001, 0, 0, 1, 2'd2, 3'b000);

    // Down trip with an intermediate call latched while moving.
    bus.call = 3'b001; tick(); bus.call = 3'b000;
    expect_out("call1_latched", 3'b001, 0, 0, 1, 2'd2, 3'b001);
    tick();
    expect_out("down_start", 3'b001, 1, 0, 0, 2'd2, 3'b001);
    step();
    bus.call = 3'b010; tick(); bus.call = 3'b000;
    expect_out("call2_latched", 3'b000, 1, 0, 0, 2'd2, 3'b011);
    step(); step();
    step_hi();
    expect_out("stop_f2", 3'b010, 0, 1, 0, 2'd1, 3'b001);
    repeat (19) tick();
    expect_out("door_f2_last", 3'b010, 0, 1, 0, 2'd1, 3'b001);
    tick();
    expect_out("door_f2_closed", 3'b010, 0, 0, 0, 2'd1, 3'b001);
    tick();
    expect_out("resume_down", 3'b010, 1, 0, 0, 2'd1, 3'b001);
    step(); step(); step();
    step_hi();
    expect_out("arrive_f1", 3'b100, 0, 1, 0, 2'd0, 3'b000);

    // Overload holds the door 15 extra cycles: 35 cycles open in total.
    bus.weight_limit_exceeded = 1'b1;
    repeat (15) tick();
    bus.weight_limit_exceeded = 1'b0;
    repeat (19) tick();
    expect_out("weight_door_last", 3'b100, 0, 1, 0, 2'd0, 3'b000);
    tick();
    expect_out("weight_door_closed", 3'b100, 0, 0, 0, 2'd0, 3'b000);

    // Same-floor call reopens the door; a second one at cycle 10 reloads it.
    bus.call = 3'b001; tick(); bus.call = 3'b000;
    expect_out("reopen", 3'b100, 0, 1, 0, 2'd0, 3'b000);
    repeat (9) tick();
    bus.call = 3'b001; tick(); bus.call = 3'b000;
    expect_out("reload_no_latch", 3'b100, 0, 1, 0, 2'd0, 3'b000);
    repeat (19) tick();
    expect_out("reload_last", 3'b100, 0, 1, 0, 2'd0, 3'b000);
    tick();
    expect_out("reload_closed", 3'b100, 0, 0, 0, 2'd0, 3'b000);

    // SOS mid-segment: pending flushed, new calls blocked, car finishes segment.
    bus.call = 3'b100; tick(); bus.call = 3'b000;
    tick();
    expect_out("up_again", 3'b100, 1, 0, 1, 2'd0, 3'b100);
    step(); step();
    bus.sos_mode = 1'b1; tick();
    expect_out("sos_flush", 3'b000, 1, 0, 1, 2'd0, 3'b000);
    bus.call = 3'b100; tick(); bus.call = 3'b000;
    expect_out("sos_block", 3'b000, 1, 0, 1, 2'd0, 3'b000);
    bus.sos_mode = 1'b0; tick();
    step();
    step_hi();
    expect_out("sos_stop_f2", 3'b010, 0, 1, 1, 2'd1, 3'b000);

    // Asynchronous reset at pos = 3 in the middle of a segment.
    repeat (20) tick();
    expect_out("door_closed_before_rst", 3'b010, 0, 0, 1, 2'd1, 3'b000);
    bus.call = 3'b100; tick(); bus.call = 3'b000;
    tick();
    step(); step(); step();
    expect_out("pre_reset", 3'b000, 1, 0, 1, 2'd1, 3'b100);
    tick();
    button_reset_n = 1'b0;   // between clock edges
    expect_out("async_reset", 3'b100, 0, 0, 1, 2'd0, 3'b000);
    #1;
    check("async_reset_floor", 32'(bus.floor), 32'd0);
    check("async_reset_led1", 32'(bus.led1), 32'd1);
    check("async_reset_move_handler", 32'(bus.move_handler), 32'd0);
    check("async_reset_door_open", 32'(bus.door_open), 32'd0);
    tick();
    button_reset_n = 1'b1;
    tick();
    expect_out("post_reset_idle", 3'b100, 0, 0, 1, 2'd0, 3'b000);

    repeat (3) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: never compared (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
